// File: rtl/ifetch_prefetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues to a registered-read imem and
// buffers {instr, pc} in a small FIFO ahead of IR1. Optional flush statistics: FETCH_STATS_EN.
module ifetch_prefetch_stage #(
  parameter int                 ADDR_W    = 8,
  parameter int                 DATA_W    = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(8'h0A),
  localparam int                PTR_W     = $clog2(DEPTH),
  localparam int                CNT_W     = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [15:0]       stat_flush,
  output logic [1:0]        dbg_state
);

  // Handshake: the head entry transfers on any cycle where ir_valid && ir_ready are both
  // high; ir_ready while ir_valid is low has no effect.

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_SQUASH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];

  logic              redirect_eff;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:   state_d = S_RUN;
      S_RUN:    if (redirect) state_d = S_SQUASH;
      S_SQUASH: state_d = redirect ? S_SQUASH : S_RUN;
      default:  state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_BOOT;
    else       state_q <= state_d;
  end

  // Credit counts the outstanding fetch so its return always has a free slot.
  always_comb begin
    redirect_eff = redirect && (state_q != S_BOOT);
    occupancy    = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    issue        = (state_q != S_BOOT) && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    push         = inflight_q && !redirect_eff;
    pop          = ir_valid && ir_ready;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_eff) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      if (pop)   rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      if (push)  wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      if (issue) inflight_pc_q <= fetch_pc_q;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign imem_addr  = fetch_pc_q;
  assign ir_valid   = (count_q != '0);
  assign ir_out     = ir_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
  assign ir_pc      = ir_valid ? pc_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

`ifdef FETCH_STATS_EN
  logic [15:0]    stat_q, stat_d;
  logic [CNT_W:0] flushed;
  logic [16:0]    stat_sum;

  // A pop completing in the redirect cycle was accepted, so it is not counted as flushed.
  always_comb begin
    flushed  = {1'b0, count_q} - (CNT_W+1)'(pop) + (CNT_W+1)'(inflight_q);
    stat_sum = {1'b0, stat_q} + 17'(flushed);
    stat_d   = stat_q;
    if (redirect_eff) stat_d = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_flush = stat_q;
`else
  assign stat_flush = '0;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_stage.sv
// Directed bench for ifetch_prefetch_stage: a per-cycle vector table for the main run plus
// hand sequences for stall, full-FIFO redirect, back-to-back redirect and stats/reset.
module tb_ifetch_prefetch_stage;

`ifdef FETCH_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] imem_addr, imem_rdata = 8'h00;
  logic [7:0] ir_out, ir_pc;
  logic       ir_valid;
  logic       ir_ready = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic [2:0] fifo_count;
  logic [15:0] stat_flush;
  logic [1:0] dbg_state;

  logic [7:0] w_addr, w_rdata = 8'h00;
  logic [7:0] w_out, w_pc;
  logic       w_valid;
  logic [2:0] w_count;
  logic [15:0] w_stat;
  logic [1:0] w_state;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ifetch_prefetch_stage dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fifo_count(fifo_count),
    .stat_flush(stat_flush), .dbg_state(dbg_state)
  );

  ifetch_prefetch_stage #(.RESET_PC(8'hFE)) dut_w (
    .clock(clock), .reset(reset), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .ir_out(w_out), .ir_pc(w_pc), .ir_valid(w_valid), .ir_ready(1'b1),
    .redirect(1'b0), .redirect_pc(8'h00), .fifo_count(w_count),
    .stat_flush(w_stat), .dbg_state(w_state)
  );

  // Registered-read memory whose contents are addr + 0x10.
  always @(posedge clock) begin
    imem_rdata <= imem_addr + 8'h10;
    w_rdata    <= w_addr + 8'h10;
  end

  typedef struct {
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       valid;
    logic [7:0] out;
    logic [7:0] pc;
    logic [2:0] cnt;
    logic [7:0] addr;
    logic [1:0] st;
    logic [15:0] stat;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] stat_exp(input logic [15:0] v);
    return STATS_ON ? v : 16'h0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    ir_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    // Main run: fill from reset with ir_ready=1, then one redirect to 0x40.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0A, 8'h00, 3'd0, 8'h00, 2'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0A, 8'h00, 3'd0, 8'h00, 2'd1, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0A, 8'h00, 3'd0, 8'h01, 2'd1, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00, 3'd1, 8'h02, 2'd1, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 8'h01, 3'd1, 8'h03, 2'd1, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 8'h02, 3'd1, 8'h04, 2'd1, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h13, 8'h03, 3'd1, 8'h05, 2'd1, 16'd0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h14, 8'h04, 3'd1, 8'h06, 2'd1, 16'd0};
    tbl[8]  = '{1'b1, 1'b1, 8'h40, 1'b1, 8'h15, 8'h05, 3'd1, 8'h07, 2'd1, 16'd0};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0A, 8'h00, 3'd0, 8'h40, 2'd2, 16'd1};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0A, 8'h00, 3'd0, 8'h41, 2'd1, 16'd1};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h50, 8'h40, 3'd1, 8'h42, 2'd1, 16'd1};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h51, 8'h41, 3'd1, 8'h43, 2'd1, 16'd1};

    do_reset();
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_out", 32'(ir_out), 32'h0A);
    check("rst_pc", 32'(ir_pc), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h00);
    check("rst_stat", 32'(stat_flush), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    check("w_rst_addr", 32'(w_addr), 32'hFE);
    check("w_rst_count", 32'(w_count), 32'h0);
    check("w_rst_stat", 32'(w_stat), 32'h0);
    check("w_rst_state", 32'(w_state), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      ir_ready    = tbl[i].rdy;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      check($sformatf("t%0d_valid", i), 32'(ir_valid), 32'(tbl[i].valid));
      check($sformatf("t%0d_out", i), 32'(ir_out), 32'(tbl[i].out));
      check($sformatf("t%0d_pc", i), 32'(ir_pc), 32'(tbl[i].pc));
      check($sformatf("t%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      check($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      check($sformatf("t%0d_state", i), 32'(dbg_state), 32'(tbl[i].st));
      check($sformatf("t%0d_stat", i), 32'(stat_flush), 32'(stat_exp(tbl[i].stat)));
      if (i >= 3) begin
        check($sformatf("w%0d_pc", i), 32'(w_pc), 32'(8'(8'hFB + i)));
        check($sformatf("w%0d_out", i), 32'(w_out), 32'(8'(8'h0B + i)));
      end else begin
        check($sformatf("w%0d_valid", i), 32'(w_valid), 32'h0);
      end
      tick();
    end

    // Back-to-back redirects: 0x80 then 0x90, only 0x90 may be fetched.
    redirect = 1'b1; redirect_pc = 8'h80;
    check("bb0_out", 32'(ir_out), 32'h52);
    check("bb0_pc", 32'(ir_pc), 32'h42);
    check("bb0_addr", 32'(imem_addr), 32'h44);
    tick();
    redirect = 1'b1; redirect_pc = 8'h90;
    check("bb1_valid", 32'(ir_valid), 32'h0);
    check("bb1_addr", 32'(imem_addr), 32'h80);
    check("bb1_state", 32'(dbg_state), 32'h2);
    check("bb1_stat", 32'(stat_flush), 32'(stat_exp(16'd2)));
    tick();
    redirect = 1'b0;
    check("bb2_addr", 32'(imem_addr), 32'h90);
    check("bb2_state", 32'(dbg_state), 32'h2);
    check("bb2_stat", 32'(stat_flush), 32'(stat_exp(16'd2)));
    tick();
    check("bb3_valid", 32'(ir_valid), 32'h0);
    check("bb3_addr", 32'(imem_addr), 32'h91);
    tick();
    check("bb4_out", 32'(ir_out), 32'hA0);
    check("bb4_pc", 32'(ir_pc), 32'h90);

    // Stall from reset: FIFO stops at DEPTH, fetch PC holds, then drains in order.
    do_reset();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("stall_count", 32'(fifo_count), 32'd4);
    check("stall_addr", 32'(imem_addr), 32'h04);
    begin
      logic [2:0] exp_cnt [6];
      exp_cnt[0] = 3'd4; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd2;
      exp_cnt[3] = 3'd2; exp_cnt[4] = 3'd2; exp_cnt[5] = 3'd2;
      ir_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
        check($sformatf("drain%0d_out", k), 32'(ir_out), 32'(8'(8'h10 + k)));
        check($sformatf("drain%0d_pc", k), 32'(ir_pc), 32'(8'(k)));
        check($sformatf("drain%0d_count", k), 32'(fifo_count), 32'(exp_cnt[k]));
        tick();
      end
    end

    // Full FIFO redirected to 0x40: nothing stale survives.
    do_reset();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("full_count", 32'(fifo_count), 32'd4);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    check("fr1_count", 32'(fifo_count), 32'd0);
    check("fr1_valid", 32'(ir_valid), 32'h0);
    check("fr1_out", 32'(ir_out), 32'h0A);
    check("fr1_addr", 32'(imem_addr), 32'h40);
    check("fr1_stat", 32'(stat_flush), 32'(stat_exp(16'd4)));
    tick();
    check("fr2_valid", 32'(ir_valid), 32'h0);
    tick();
    check("fr3_valid", 32'(ir_valid), 32'h1);
    check("fr3_out", 32'(ir_out), 32'h50);
    check("fr3_pc", 32'(ir_pc), 32'h40);

    // Redirect at count 3 with one fetch in flight, then reset mid-run.
    do_reset();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("s6_count", 32'(fifo_count), 32'd3);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    check("s6_stat", 32'(stat_flush), 32'(stat_exp(16'd4)));
    check("s6_count0", 32'(fifo_count), 32'd0);
    ir_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_stat", 32'(stat_flush), 32'h0);
    check("mid_rst_count", 32'(fifo_count), 32'h0);
    check("mid_rst_valid", 32'(ir_valid), 32'h0);
    check("mid_rst_out", 32'(ir_out), 32'h0A);
    check("mid_rst_pc", 32'(ir_pc), 32'h0);
    check("mid_rst_addr", 32'(imem_addr), 32'h00);
    check("mid_rst_state", 32'(dbg_state), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
